nibble_serial_add_ctrl: RTL and testbench

//   Sequences one shared 4-bit adder (adder_4bit, instantiated inside) to add two

---
 rtl/nibble_serial_add_ctrl_if.sv | 18 +
 rtl/nibble_serial_add_ctrl.sv | 78 +++++++
 tb/tb_nibble_serial_add_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if: start/operand/result bundle for the serial nibble adder
//   start  master->slave  request, sampled only when the slave is idle or done
//   a, b   master->slave  W-bit operands, captured on the accepted start
//   busy   slave->master  high while nibbles are being added
//   done   slave->master  one-cycle pulse, sum/cout valid
//   sum    slave->master  W-bit result register
//   cout   slave->master  carry out of the top nibble
interface nibble_serial_add_ctrl_if #(parameter int NIBBLES = 4);
   logic                   start;
   logic [4*NIBBLES-1:0]   a;
   logic [4*NIBBLES-1:0]   b;
   logic                   busy;
   logic                   done;
   logic [4*NIBBLES-1:0]   sum;
   logic                   cout;
   modport master (output start, a, b, input busy, done, sum, cout);
   modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds two 4*NIBBLES-bit operands one nibble per cycle on a shared 4-bit adder
//   clk    in  system clock, rising edge
//   rst_n  in  synchronous active-low reset
//   bus    slave side of nibble_serial_add_ctrl_if (start, a, b, busy, done, sum, cout)
module adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] s,
   output logic       co
);
   assign {co, s} = {1'b0, a} + {1'b0, b};
endmodule

module nibble_serial_add_ctrl #(parameter int NIBBLES = 4) (
   input  logic                     clk,
   input  logic                     rst_n,
   nibble_serial_add_ctrl_if.slave  bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t          state;
   logic [W-1:0]    opa, opb;
   logic            carry;
   logic [IW-1:0]   idx;
   logic [3:0]      add_s;
   logic            add_co;
   logic [4:0]      t;
   logic            nxt_carry;
   adder_4bit u_add (.a(opa[idx*4 +: 4]), .b(opb[idx*4 +: 4]), .s(add_s), .co(add_co));
   // adder has no carry-in, so the held carry is merged here; add_co and t[4] are mutually exclusive
   assign t         = {1'b0, add_s} + {4'b0, carry};
   assign nxt_carry = add_co | t[4];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.sum  <= '0;
         bus.cout <= 1'b0;
         carry    <= 1'b0;
         idx      <= '0;
         opa      <= '0;
         opb      <= '0;
      end else begin
         case (state)
            RUN: begin
               bus.sum[idx*4 +: 4] <= t[3:0];
               carry               <= nxt_carry;
               if (idx == LAST) begin
                  state    <= DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  bus.cout <= nxt_carry;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  state    <= RUN;
                  bus.busy <= 1'b1;
                  bus.sum  <= '0;
                  bus.cout <= 1'b0;
                  opa      <= bus.a;
                  opb      <= bus.b;
                  carry    <= 1'b0;
                  idx      <= '0;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: randomized and directed checks of the serial nibble adder against a cycle model
module tb_nibble_serial_add_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   en = 1'b0;
   always #5 clk = ~clk;
   nibble_serial_add_ctrl_if #(.NIBBLES(4)) b1 ();
   nibble_serial_add_ctrl_if #(.NIBBLES(2)) b2 ();
   nibble_serial_add_ctrl #(.NIBBLES(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
   nibble_serial_add_ctrl #(.NIBBLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // phase k: 0 idle, 1..4 busy cycles, 5 done cycle
   int          k = 0;
   logic [16:0] res = '0;
   logic [16:0] exp_res = '0;
   always @(posedge clk) begin
      if (!rst_n) begin
         k = 0;
         exp_res = '0;
      end else if ((k == 0 || k == 5) && b1.start) begin
         k = 1;
         res = {1'b0, b1.a} + {1'b0, b1.b};
         exp_res = '0;
      end else if (k >= 1 && k <= 4) begin
         k = k + 1;
         if (k == 5) exp_res = res;
      end else begin
         k = 0;
      end
   end
   always @(negedge clk) begin
      if (en) begin
         chk("busy", {31'b0, b1.busy}, {31'b0, (k >= 1 && k <= 4)});
         chk("done", {31'b0, b1.done}, {31'b0, (k == 5)});
         if (!(k >= 1 && k <= 4)) chk("result", {15'b0, b1.cout, b1.sum}, {15'b0, exp_res});
      end
   end
   task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic [15:0] es, input logic ec);
      int lat;
      b1.a = a;
      b1.b = b;
      b1.start = 1'b1;
      @(posedge clk);
      #1;
      b1.start = 1'b0;
      b1.a = 16'($urandom);
      b1.b = 16'($urandom);
      lat = 0;
      while (!b1.done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", lat, 4);
      chk("sum_lit", {16'b0, b1.sum}, {16'b0, es});
      chk("cout_lit", {31'b0, b1.cout}, {31'b0, ec});
   endtask
   initial begin
      int lat, last, gap;
      b1.start = 1'b0;
      b1.a = '0;
      b1.b = '0;
      b2.start = 1'b0;
      b2.a = '0;
      b2.b = '0;
      repeat (2) @(posedge clk);
      #1;
      en = 1'b1;
      chk("rst_busy", {31'b0, b1.busy}, 32'd0);
      chk("rst_sum", {16'b0, b1.sum}, 32'd0);
      chk("rst2_sum", {24'b0, b2.sum}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      op1(16'h1234, 16'h4321, 16'h5555, 1'b0);
      op1(16'hFFFF, 16'h0001, 16'h0000, 1'b1);
      op1(16'h8000, 16'h8000, 16'h0000, 1'b1);
      op1(16'h0009, 16'h0009, 16'h0012, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("idle_hold", {16'b0, b1.sum}, 32'h0012);
      b1.start = 1'b1;
      last = -1;
      gap = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         b1.a = 16'($urandom);
         b1.b = 16'($urandom);
         if (b1.done) begin
            if (last >= 0) gap = i - last;
            last = i;
         end
      end
      chk("done_period", gap, 5);
      b1.start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      b1.a = 16'h1234;
      b1.b = 16'h4321;
      b1.start = 1'b1;
      @(posedge clk);
      #1;
      b1.start = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("midrst_busy", {31'b0, b1.busy}, 32'd0);
      chk("midrst_done", {31'b0, b1.done}, 32'd0);
      chk("midrst_res", {15'b0, b1.cout, b1.sum}, 32'd0);
      lat = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (b1.done) lat++;
      end
      chk("midrst_nodone", lat, 0);
      for (int i = 0; i < 400; i++) begin
         b1.start = ($urandom_range(0, 3) == 0);
         b1.a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         b1.b = 16'($urandom);
         rst_n = ($urandom_range(0, 99) != 0);
         @(posedge clk);
         #1;
      end
      b1.start = 1'b0;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      b2.a = 8'hA7;
      b2.b = 8'h5C;
      b2.start = 1'b1;
      @(posedge clk);
      #1;
      b2.start = 1'b0;
      b2.a = 8'h00;
      b2.b = 8'h00;
      lat = 0;
      while (!b2.done && lat < 20) begin
         chk("n2_busy", {31'b0, b2.busy}, 32'd1);
         @(posedge clk);
         #1;
         lat++;
      end
      chk("n2_latency", lat, 2);
      chk("n2_sum", {24'b0, b2.sum}, 32'h03);
      chk("n2_cout", {31'b0, b2.cout}, 32'd1);
      @(posedge clk);
      #1;
      chk("n2_done_pulse", {31'b0, b2.done}, 32'd0);
      chk("n2_hold", {23'b0, b2.cout, b2.sum}, 32'h103);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
